// File: rtl/ex_bus_read_engine_if.sv
// Scratchpad-side bus and host read-stream bundle for the readback engine.
// master = engine side, slave = scratchpad model plus host sink.
interface ex_bus_read_engine_if #(
    parameter int A_W = 10,
    parameter int D_W = 32
) ();
    // {ex_wen, ex_ren, ex_addr, ex_data}
    logic [A_W+D_W+1:0] ex_bus;
    logic [D_W-1:0]     rd_data;
    logic               out_valid;
    logic [D_W-1:0]     out_data;
    logic               out_last;
    logic               out_ready;

    modport master (
        output ex_bus,
        output out_valid,
        output out_data,
        output out_last,
        input  rd_data,
        input  out_ready
    );

    modport slave (
        input  ex_bus,
        input  out_valid,
        input  out_data,
        input  out_last,
        output rd_data,
        output out_ready
    );
endinterface

// File: rtl/ex_bus_read_engine.sv
// Generic FWFT FIFO: count-tracked circular buffer with a registered head pointer.
// Latency: a word written at an edge is visible on rd_dat right after that edge.
// Backpressure: writes are dropped when full unless a read happens in the same cycle.
module generic_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        do_rd  = rd_rdy && (cnt_q != '0);
        do_wr  = wr_vld && ((cnt_q != CNT_W'(DEPTH)) || do_rd);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_wr) wptr_d = wptr_q + PTR_W'(1);
        if (do_rd) rptr_d = rptr_q + PTR_W'(1);
        cnt_d  = cnt_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; the head is only meaningful while rd_vld is high.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_dat;
    end

    assign rd_vld = (cnt_q != '0);
    assign rd_dat = mem_q[rptr_q];
    assign cnt    = cnt_q;
endmodule

// Burst read master: issues ex_ren over an address range, streams read data out (EXR_STALL_CNT_EN adds stall_cnt).
// Latency: first ex_ren one cycle after the start edge; each word at out_valid READ_LAT+1 cycles after its ex_ren.
// Backpressure: reads issue only while in-flight + buffered < FIFO_DEPTH, so out_ready may stall indefinitely.
module ex_bus_read_engine #(
    parameter int A_W        = 10,
    parameter int D_W        = 32,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_W-1:0]       base_addr,
    input  logic [A_W:0]         length,
    output logic                 busy,
    output logic                 done,
    ex_bus_read_engine_if.master bus
`ifdef EXR_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LAT + 2) + 1;
    localparam logic [A_W:0] ONE_LEN = 1;

    logic [1:0]          state_q, state_d;
    logic [A_W-1:0]      addr_q, addr_d;
    logic [A_W:0]        remaining_q, remaining_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ex_ren_q, ex_ren_d;
    logic [A_W-1:0]      ex_addr_q, ex_addr_d;
    logic                ex_last_q, ex_last_d;
    logic [READ_LAT-1:0] vld_sr_q, vld_sr_d;
    logic [READ_LAT-1:0] last_sr_q, last_sr_d;

    logic                cap_vld;
    logic                cap_last;
    logic                fifo_vld;
    logic [D_W:0]        fifo_dat;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                pop;
    logic [OCC_W-1:0]    inflight;
    logic                credit;
    logic                issue;

    assign cap_vld  = vld_sr_q[READ_LAT-1];
    assign cap_last = last_sr_q[READ_LAT-1];
    assign pop      = fifo_vld && bus.out_ready;

    generic_fifo #(
        .W     (D_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .wr_vld (cap_vld),
        .wr_dat ({cap_last, bus.rd_data}),
        .rd_rdy (bus.out_ready),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_dat),
        .cnt    (fifo_cnt)
    );

    // The registered ex_ren counts as in flight: it has been committed to the bus.
    always_comb begin
        inflight = OCC_W'(ex_ren_q);
        for (int i = 0; i < READ_LAT; i++) begin
            inflight = inflight + OCC_W'(vld_sr_q[i]);
        end
        credit = (inflight + OCC_W'(fifo_cnt)) < OCC_W'(FIFO_DEPTH);
        issue  = (state_q == S_ISSUE) && credit;
    end

    always_comb begin
        vld_sr_d     = vld_sr_q;
        last_sr_d    = last_sr_q;
        vld_sr_d[0]  = ex_ren_q;
        last_sr_d[0] = ex_last_q;
        for (int i = 1; i < READ_LAT; i++) begin
            vld_sr_d[i]  = vld_sr_q[i-1];
            last_sr_d[i] = last_sr_q[i-1];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ex_ren_d    = 1'b0;
        ex_addr_d   = '0;
        ex_last_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = length;
                    busy_d      = 1'b1;
                    state_d     = (length == '0) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    ex_ren_d    = 1'b1;
                    ex_addr_d   = addr_q;
                    ex_last_d   = (remaining_q == ONE_LEN);
                    addr_d      = addr_q + A_W'(1);
                    remaining_d = remaining_q - ONE_LEN;
                    if (remaining_q == ONE_LEN) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave on the edge that accepts the final word so done follows it by one cycle.
                if ((inflight == '0) &&
                    ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop))) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ex_ren_q    <= 1'b0;
            ex_addr_q   <= '0;
            ex_last_q   <= 1'b0;
            vld_sr_q    <= '0;
            last_sr_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ex_ren_q    <= ex_ren_d;
            ex_addr_q   <= ex_addr_d;
            ex_last_q   <= ex_last_d;
            vld_sr_q    <= vld_sr_d;
            last_sr_q   <= last_sr_d;
        end
    end

`ifdef EXR_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == S_ISSUE) && !credit && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cnt = stall_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.ex_bus    = {1'b0, ex_ren_q, ex_addr_q, {D_W{1'b0}}};
    assign bus.out_valid = fifo_vld;
    assign bus.out_data  = fifo_vld ? fifo_dat[D_W-1:0] : '0;
    assign bus.out_last  = fifo_vld && fifo_dat[D_W];
endmodule

// File: tb/tb_ex_bus_read_engine.sv
// Bench for ex_bus_read_engine: READ_LAT=1 and READ_LAT=3 instances against a preloaded scratchpad.
module tb_ex_bus_read_engine;
    localparam int A_W = 10;
    localparam int D_W = 32;

    typedef struct {
        int sel;
        int base;
        int len;
        int stall;
        int restart_k;
        int rnd;
        int exp_n;
        int exp_first;
        int exp_last;
        int exp_pre;
        int exp_stall_min;
    } vec_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           sel;
    logic           start_s;
    logic [A_W-1:0] base_s;
    logic [A_W:0]   len_s;
    logic           ready_s;
    logic           busy1, done1, busy3, done3;
    logic [D_W-1:0] mem [1024];
    logic [D_W-1:0] rp1, rp3a, rp3b, rp3c;
    int             n_checks = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    ex_bus_read_engine_if #(.A_W(A_W), .D_W(D_W)) bus1 ();
    ex_bus_read_engine_if #(.A_W(A_W), .D_W(D_W)) bus3 ();

`ifdef EXR_STALL_CNT_EN
    logic [15:0] stall1, stall3, stall_mon;
    assign stall_mon = sel ? stall3 : stall1;
`endif

    ex_bus_read_engine #(.A_W(A_W), .D_W(D_W), .READ_LAT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst(rst), .start(start_s && !sel), .base_addr(base_s), .length(len_s),
        .busy(busy1), .done(done1), .bus(bus1)
`ifdef EXR_STALL_CNT_EN
        , .stall_cnt(stall1)
`endif
    );

    ex_bus_read_engine #(.A_W(A_W), .D_W(D_W), .READ_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst(rst), .start(start_s && sel), .base_addr(base_s), .length(len_s),
        .busy(busy3), .done(done3), .bus(bus3)
`ifdef EXR_STALL_CNT_EN
        , .stall_cnt(stall3)
`endif
    );

    // Scratchpad models: registered read, then extra pipeline stages for READ_LAT=3.
    always @(posedge clk) begin
        if (bus1.ex_bus[A_W+D_W]) rp1 <= mem[bus1.ex_bus[A_W+D_W-1:D_W]];
        if (bus3.ex_bus[A_W+D_W]) rp3a <= mem[bus3.ex_bus[A_W+D_W-1:D_W]];
        rp3b <= rp3a;
        rp3c <= rp3b;
    end
    assign bus1.rd_data   = rp1;
    assign bus3.rd_data   = rp3c;
    assign bus1.out_ready = ready_s && !sel;
    assign bus3.out_ready = ready_s && sel;

    logic           mon_ren, mon_wen, mon_valid, mon_last, mon_done;
    logic [A_W-1:0] mon_addr;
    logic [D_W-1:0] mon_data, mon_exdata;
    assign mon_ren    = sel ? bus3.ex_bus[A_W+D_W]   : bus1.ex_bus[A_W+D_W];
    assign mon_wen    = sel ? bus3.ex_bus[A_W+D_W+1] : bus1.ex_bus[A_W+D_W+1];
    assign mon_addr   = sel ? bus3.ex_bus[A_W+D_W-1:D_W] : bus1.ex_bus[A_W+D_W-1:D_W];
    assign mon_exdata = sel ? bus3.ex_bus[D_W-1:0]   : bus1.ex_bus[D_W-1:0];
    assign mon_valid  = sel ? bus3.out_valid : bus1.out_valid;
    assign mon_data   = sel ? bus3.out_data  : bus1.out_data;
    assign mon_last   = sel ? bus3.out_last  : bus1.out_last;
    assign mon_done   = sel ? done3 : done1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_word(input int a);
        return (a % 1024) + 1;
    endfunction

    task automatic run_burst(input vec_t v, input int idx);
        int ren_cnt = 0, pre = 0, addr_err = 0, data_err = 0, bus_err = 0;
        int words = 0, first_w = -1, last_w = -1, last_cnt = 0;
        int first_ren_k = -1, last_ren_k = -1, first_vld_k = -1;
        int last_hs_k = -1, done_k = -1, done_cnt = 0;
        int budget = v.len * 8 + v.stall + 60;
        string p = $sformatf("v%0d_", idx);
        sel = (v.sel != 0);
        @(negedge clk);
        base_s  = A_W'(v.base);
        len_s   = (A_W+1)'(v.len);
        start_s = 1'b1;
        ready_s = (v.rnd == 0) && (v.stall == 0);
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (k == 1 || (v.restart_k > 0 && k == v.restart_k + 1)) start_s = 1'b0;
            if (v.restart_k > 0 && k == v.restart_k) begin
                start_s = 1'b1;
                base_s  = A_W'(500);
                len_s   = (A_W+1)'(3);
            end
            ready_s = (v.rnd != 0) ? ($urandom_range(0, 1) == 1) : (k >= v.stall);
            if (mon_wen || mon_exdata != '0) bus_err++;
            if (mon_ren) begin
                if (int'(mon_addr) != (v.base + ren_cnt) % 1024) addr_err++;
                if (first_ren_k < 0) first_ren_k = k;
                last_ren_k = k;
                if (k < v.stall) pre++;
                ren_cnt++;
            end
            if (mon_valid && first_vld_k < 0) first_vld_k = k;
            if (mon_valid && ready_s) begin
                if (mon_data != D_W'(exp_word(v.base + words))) data_err++;
                if (words == 0) first_w = int'(mon_data);
                if (mon_last) begin
                    last_cnt++;
                    last_w = int'(mon_data);
                end
                words++;
                last_hs_k = k;
            end
            if (mon_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        check({p, "words"}, words, v.exp_n);
        check({p, "reads"}, ren_cnt, v.len);
        check({p, "addr_err"}, addr_err, 0);
        check({p, "data_err"}, data_err, 0);
        check({p, "bus_err"}, bus_err, 0);
        check({p, "pre_stall_reads"}, pre, v.exp_pre);
        check({p, "last_cnt"}, last_cnt, (v.exp_n > 0) ? 1 : 0);
        check({p, "done_cnt"}, done_cnt, 1);
        check({p, "done_k"}, done_k, (v.len == 0) ? 2 : last_hs_k + 2);
        if (v.exp_n > 0) begin
            check({p, "first_word"}, first_w, v.exp_first);
            check({p, "last_word"}, last_w, v.exp_last);
            check({p, "first_ren_k"}, first_ren_k, 2);
            check({p, "first_vld_lat"}, first_vld_k - first_ren_k, (v.sel != 0) ? 4 : 2);
        end
        if (v.len > 0 && v.stall == 0 && v.rnd == 0 && v.sel == 0)
            check({p, "back_to_back"}, last_ren_k - first_ren_k, v.len - 1);
`ifdef EXR_STALL_CNT_EN
        check({p, "stall_cnt_min"}, (int'(stall_mon) >= v.exp_stall_min) ? 1 : 0, 1);
`endif
    endtask

    vec_t vecs [7];
    vec_t rvec;

    initial begin
        int ren_cnt;
        int stale;
        for (int i = 0; i < 1024; i++) mem[i] = D_W'(i + 1);
        rst = 1'b1; sel = 1'b0; start_s = 1'b0; base_s = '0; len_s = '0; ready_s = 1'b0;

        //          sel base  len stall rk rnd  n  first last pre smin
        vecs[0] = '{0,   1,   10,  0,  0, 0,  10,   2,  11,  0,  0};
        vecs[1] = '{0,   0,    8, 20,  0, 0,   8,   1,   8,  4, 16};
        vecs[2] = '{0, 1022,   4,  0,  0, 0,   4, 1023,   2,  0,  0};
        vecs[3] = '{0, 100,    1,  3,  0, 0,   1, 101, 101,  1,  0};
        vecs[4] = '{0, 1023,   2,  0,  0, 0,   2, 1024,   1,  0,  0};
        vecs[5] = '{0, 200,    6,  0,  4, 0,   6, 201, 206,  0,  0};
        vecs[6] = '{0,   7,    0,  0,  0, 0,   0,   0,   0,  0,  0};

        #2 rst = 1'b0;
        #1;
        check("rst_busy", int'(busy1), 0);
        check("rst_done", int'(done1), 0);
        check("rst_valid", int'(bus1.out_valid), 0);
        check("rst_last", int'(bus1.out_last), 0);
        check("rst_data", int'(bus1.out_data), 0);
        check("rst_ex_bus", int'(bus1.ex_bus == '0), 1);
        check("rst_valid3", int'(bus3.out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_burst(vecs[i], i);

        // Reset in the middle of a burst after three reads have issued.
        sel = 1'b0;
        @(negedge clk);
        base_s = A_W'(5); len_s = (A_W+1)'(8); start_s = 1'b1; ready_s = 1'b0;
        ren_cnt = 0;
        for (int k = 1; k <= 20 && ren_cnt < 3; k++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (mon_ren) ren_cnt++;
        end
        check("mid_rst_issued", ren_cnt, 3);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", int'(busy1), 0);
        check("mid_rst_valid", int'(bus1.out_valid), 0);
        check("mid_rst_ex_bus", int'(bus1.ex_bus == '0), 1);
        @(negedge clk);
        rst = 1'b1;
        ready_s = 1'b1;
        stale = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus1.out_valid || mon_ren || busy1) stale++;
        end
        check("mid_rst_stale", stale, 0);

        // Long burst with random ready on the READ_LAT=3 instance.
        rvec = '{1, 0, 1024, 0, 0, 1, 1024, 1, 1024, 0, 0};
        run_burst(rvec, 7);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
